store_buffer_coalesce: RTL

Parametrised store buffer between the LSU/MMU store path and the data cache, succeeding `store_buffer_top`. It queues up to `BLEN` stores in a circular FIFO and drains them in order to the dcache with a req/ack handshake. Unlike its predecessor, it merges a store into the youngest entry when both target the same word. It can optionally forward buffered bytes to younger loads.

---
 rtl/store_buffer_coalesce.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/store_buffer_coalesce.sv
// Coalescing store buffer: in-order circular FIFO of stores drained to the dcache via req/ack.
// Optional store-to-load forwarding is built when STB_LOAD_FWD_EN is defined.
module store_buffer_coalesce #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = DATA_WIDTH/8,
    parameter int BLEN           = 4,
    parameter int BLEN_IDX       = $clog2(BLEN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     lsummu2stb_addr,
    input  logic [DATA_WIDTH-1:0]     lsummu2stb_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_sel_byte,
    input  logic                      lsummu2stb_w_en,
    input  logic                      lsummu2stb_req,
    input  logic                      dmem_sel_i,
    input  logic [ADDR_WIDTH-1:0]     lsummu2stb_ld_addr,
    output logic                      stb2lsummu_stall,
    output logic                      stb2lsummu_ack,
    output logic [DATA_WIDTH-1:0]     stb2lsummu_fwd_data,
    output logic [BYTE_SEL_WIDTH-1:0] stb2lsummu_fwd_mask,
    output logic                      stb2lsummu_fwd_hit,
    output logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    output logic                      stb2dcache_w_en,
    output logic                      stb2dcache_req,
    output logic                      stb2dcache_empty,
    output logic                      dmem_sel_o,
    input  logic                      dcache2stb_ack
);

    // state   | meaning
    // IDLE    | nothing presented to the dcache, head outputs forced to zero
    // REQ     | head entry presented with req held until dcache ack

    localparam int                OFF      = $clog2(BYTE_SEL_WIDTH);
    localparam logic [BLEN_IDX:0] CNT_FULL = (BLEN_IDX+1)'(BLEN);
    localparam logic [BLEN_IDX:0] CNT_ONE  = (BLEN_IDX+1)'(1);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     ent_addr [BLEN];
    logic [DATA_WIDTH-1:0]     ent_data [BLEN];
    logic [BYTE_SEL_WIDTH-1:0] ent_mask [BLEN];
    logic [BLEN-1:0]           ent_dsel;
    logic [BLEN-1:0]           ent_valid;
    logic [BLEN_IDX-1:0]       wr_ptr;
    logic [BLEN_IDX-1:0]       rd_ptr;
    logic [BLEN_IDX:0]         count;
    logic                      ack_q;

    logic [BLEN_IDX-1:0]       tail_idx;
    logic                      coalesce_hit;
    logic                      store;
    logic                      push_new;
    logic                      pop;

    assign tail_idx = wr_ptr - 1'b1;

    // The head being drained must stay frozen, so it is never a merge target in REQ.
    assign coalesce_hit = (count != '0) && ent_valid[tail_idx]
                       && (ent_addr[tail_idx][ADDR_WIDTH-1:OFF] == lsummu2stb_addr[ADDR_WIDTH-1:OFF])
                       && !((state == ST_REQ) && (tail_idx == rd_ptr));

    assign stb2lsummu_stall = (count == CNT_FULL) && !coalesce_hit;
    assign store            = lsummu2stb_req && lsummu2stb_w_en && !stb2lsummu_stall;
    assign push_new         = store && !coalesce_hit;
    assign pop              = (state == ST_REQ) && dcache2stb_ack;
    assign stb2lsummu_ack   = ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLEN; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_mask[i] <= '0;
            end
            ent_dsel  <= '0;
            ent_valid <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= store;
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (store && coalesce_hit) begin
                for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
                    if (lsummu2stb_sel_byte[b]) begin
                        ent_data[tail_idx][8*b +: 8] <= lsummu2stb_wdata[8*b +: 8];
                    end
                end
                ent_mask[tail_idx] <= ent_mask[tail_idx] | lsummu2stb_sel_byte;
            end else if (push_new) begin
                ent_addr[wr_ptr]  <= lsummu2stb_addr;
                ent_data[wr_ptr]  <= lsummu2stb_wdata;
                ent_mask[wr_ptr]  <= lsummu2stb_sel_byte;
                ent_dsel[wr_ptr]  <= dmem_sel_i;
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (push_new && !pop) begin
                count <= count + 1'b1;
            end else if (!push_new && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (count != '0) state <= ST_REQ;
                ST_REQ:  if (dcache2stb_ack && !(count > CNT_ONE)) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stb2dcache_req      = (state == ST_REQ);
    assign stb2dcache_w_en     = stb2dcache_req;
    assign stb2dcache_empty    = (count == '0);
    assign stb2dcache_addr     = stb2dcache_req ? ent_addr[rd_ptr] : '0;
    assign stb2dcache_wdata    = stb2dcache_req ? ent_data[rd_ptr] : '0;
    assign stb2dcache_sel_byte = stb2dcache_req ? ent_mask[rd_ptr] : '0;
    assign dmem_sel_o          = stb2dcache_req ? ent_dsel[rd_ptr] : 1'b0;

`ifdef STB_LOAD_FWD_EN
    logic [BLEN_IDX-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest matching byte wins.
    always_comb begin
        stb2lsummu_fwd_data = '0;
        stb2lsummu_fwd_mask = '0;
        fwd_idx             = '0;
        for (int k = 0; k < BLEN; k++) begin
            fwd_idx = rd_ptr + BLEN_IDX'(k);
            if (ent_valid[fwd_idx]
                && (ent_addr[fwd_idx][ADDR_WIDTH-1:OFF] == lsummu2stb_ld_addr[ADDR_WIDTH-1:OFF])) begin
                for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
                    if (ent_mask[fwd_idx][b]) begin
                        stb2lsummu_fwd_data[8*b +: 8] = ent_data[fwd_idx][8*b +: 8];
                        stb2lsummu_fwd_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end

    assign stb2lsummu_fwd_hit = &stb2lsummu_fwd_mask;
`else
    logic unused_ld_addr;

    assign unused_ld_addr      = ^lsummu2stb_ld_addr;
    assign stb2lsummu_fwd_data = '0;
    assign stb2lsummu_fwd_mask = '0;
    assign stb2lsummu_fwd_hit  = 1'b0;
`endif

endmodule
